// File: rtl/div_seq_pkg.sv
// Shared constants for the sequential RV32M divider: opcode/func fields,
// divide func3 codes, FSM state encoding and a small sign helper.
package div_seq_pkg;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_M_FUNC7  = 7'b0000001;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam int unsigned DIV_BITS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement negate when neg is set; used for both magnitude and sign fix-up.
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it does not underflow.
module div_step (
    input  logic [32:0] rem_i,
    input  logic        bit_i,
    input  logic [31:0] divisor_i,
    output logic [32:0] rem_o,
    output logic        quo_bit_o
);

    logic [33:0] shifted_w;
    logic [32:0] trial_w;

    // The compare uses the full 34-bit shifted value; the difference itself
    // always fits in 33 bits because it is smaller than the divisor.
    assign shifted_w = {rem_i, bit_i};
    assign quo_bit_o = (shifted_w >= {2'b00, divisor_i});
    assign trial_w   = shifted_w[32:0] - {1'b0, divisor_i};
    assign rem_o     = quo_bit_o ? trial_w : shifted_w[32:0];

endmodule

// File: rtl/div_seq.sv
// Sequential RV32M divider: DIV/DIVU/REM/REMU in 33 cycles, divide-by-zero
// in 1 cycle; stalls the pipeline while computing and is abortable by flush.
module div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        hold_flag_o,
    output logic        busy_o,
    output logic        rd_wen_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o
);

    import div_seq_pkg::*;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;      // dividend magnitude, shifts left as quotient bits fill in
    logic [31:0] dvs_q;
    logic [32:0] rem_q;
    logic [31:0] result_q;
    logic [4:0]  rd_addr_q;
    logic        rem_sel_q;
    logic        quo_neg_q;
    logic        rem_neg_q;

    logic        accept_w;
    logic        signed_op_w;
    logic        dvd_neg_w;
    logic        dvs_neg_w;
    logic [32:0] step_rem_w;
    logic        step_bit_w;
    logic        done_vis_w;

    assign accept_w    = (state_q == IDLE) && start_i && !flush_i && func3_i[2];
    assign signed_op_w = !func3_i[0];
    assign dvd_neg_w   = signed_op_w && dividend_i[31];
    assign dvs_neg_w   = signed_op_w && divisor_i[31];

    div_step u_div_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[31]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_w),
        .quo_bit_o (step_bit_w)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            rd_addr_q <= '0;
            rem_sel_q <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_w) begin
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        rd_addr_q <= rd_addr_i;
                        rem_sel_q <= func3_i[1];
                        quo_neg_q <= dvd_neg_w ^ dvs_neg_w;
                        rem_neg_q <= dvd_neg_w;
                        dvd_q     <= neg_if(dvd_neg_w, dividend_i);
                        dvs_q     <= neg_if(dvs_neg_w, divisor_i);
                        if (divisor_i == '0) begin
                            // Divide by zero skips the iterations; remainder is the raw dividend.
                            result_q <= func3_i[1] ? dividend_i : 32'hFFFF_FFFF;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        dvd_q <= {dvd_q[30:0], step_bit_w};
                        rem_q <= step_rem_w;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'(DIV_BITS - 1)) begin
                            state_q  <= DONE;
                            cnt_q    <= '0;
                            result_q <= rem_sel_q ? neg_if(rem_neg_q, step_rem_w[31:0])
                                                  : neg_if(quo_neg_q, {dvd_q[30:0], step_bit_w});
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done_vis_w = (state_q == DONE) && !flush_i;

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_wen_o    = 1'b0;
        rd_addr_o   = '0;
        rd_data_o   = '0;
        busy_o      = (state_q != IDLE);
        // Gated by rst_n so a start held during reset cannot raise a stall.
        hold_flag_o = rst_n && (accept_w || (state_q == CALC));
        if (done_vis_w) begin
            rd_wen_o  = 1'b1;
            rd_addr_o = rd_addr_q;
            rd_data_o = result_q;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: cycle-accurate latency model plus
// arithmetic reference, directed corner cases and randomized traffic.
module tb_div_seq;

    import div_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  func3_i = '0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        hold_flag_o;
    logic        busy_o;
    logic        rd_wen_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    int total = 0;
    int bad   = 0;

    div_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .func3_i     (func3_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .rd_addr_i   (rd_addr_i),
        .flush_i     (flush_i),
        .hold_flag_o (hold_flag_o),
        .busy_o      (busy_o),
        .rd_wen_o    (rd_wen_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_o   (rd_data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension semantics from plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
            return f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return f3[1] ? a % b : a / b;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Cycle model: an accepted op is "in flight" for lat cycles; its write
    // appears at age == lat unless flushed.
    initial begin
        bit          flying = 0;
        int          age = 0;
        int          lat = 0;
        logic        acc;
        logic [31:0] exp_d = '0;
        logic [4:0]  exp_a = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_ctl", {29'b0, rd_wen_o, busy_o, hold_flag_o}, 32'h0);
                check("rst_data", rd_data_o, 32'h0);
                check("rst_addr", 32'(rd_addr_o), 32'h0);
                flying = 0;
            end else begin
                acc = !flying && start_i && !flush_i && func3_i[2];
                check("mdl_busy", 32'(busy_o), 32'(flying));
                check("mdl_hold", 32'(hold_flag_o), 32'(acc || (flying && age < lat)));
                if (flying && age == lat) begin
                    check("mdl_wen", 32'(rd_wen_o), 32'(!flush_i));
                    if (!flush_i) begin
                        check("mdl_data", rd_data_o, exp_d);
                        check("mdl_addr", 32'(rd_addr_o), 32'(exp_a));
                    end
                end else begin
                    check("mdl_idle_wen", 32'(rd_wen_o), 32'h0);
                    check("mdl_idle_data", rd_data_o, 32'h0);
                    check("mdl_idle_addr", 32'(rd_addr_o), 32'h0);
                end
                if (flying) begin
                    if (flush_i || age == lat) flying = 0;
                    else age++;
                end else if (acc) begin
                    flying = 1;
                    age    = 1;
                    lat    = (divisor_i == 0) ? 1 : 33;
                    exp_d  = ref_result(func3_i, dividend_i, divisor_i);
                    exp_a  = rd_addr_i;
                end
            end
        end
    end

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] addr);
        start_i    = 1'b1;
        func3_i    = f3;
        dividend_i = a;
        divisor_i  = b;
        rd_addr_i  = addr;
    endtask

    // Issue one request and wait (bounded) for its write; checks latency,
    // data, address and number of stalled cycles.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] addr,
                          input logic [31:0] exp_d, input int exp_lat);
        int          n = 0;
        int          got = -1;
        int          holds = 0;
        logic [31:0] d = '0;
        logic [4:0]  ad = '0;
        @(posedge clk); #1;
        drive_req(f3, a, b, addr);
        while (n <= 40 && got < 0) begin
            @(negedge clk);
            if (rd_wen_o) begin
                got = n;
                d   = rd_data_o;
                ad  = rd_addr_o;
            end else begin
                if (hold_flag_o) holds++;
                @(posedge clk); #1;
                start_i = 1'b0;
                n++;
            end
        end
        check({name, "_lat"}, 32'(got), 32'(exp_lat));
        check({name, "_data"}, d, exp_d);
        check({name, "_addr"}, 32'(ad), 32'(addr));
        check({name, "_holds"}, 32'(holds), 32'(exp_lat));
    endtask

    initial begin
        int writes;
        int wcyc;
        logic [31:0] wdata;
        logic [4:0]  waddr;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        start_i = 1'b1; func3_i = INST_DIVU; divisor_i = 32'd7;
        @(negedge clk);
        check("reset_wen", 32'(rd_wen_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);
        check("reset_hold", 32'(hold_flag_o), 32'h0);
        @(posedge clk); #1;
        start_i = 1'b0;
        rst_n   = 1'b1;

        // Pin the reference model with hand-computed values
        check("ref_divu_100_7", ref_result(INST_DIVU, 100, 7), 32'd14);
        check("ref_rem_m7_2", ref_result(INST_REM, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
        check("ref_div_m7_2", ref_result(INST_DIV, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
        check("ref_remu_by0", ref_result(INST_REMU, 1234, 0), 32'd1234);
        check("ref_div_ovf", ref_result(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        check("ref_rem_ovf", ref_result(INST_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

        // Directed operations against literal results
        run_op("divu_100_7", INST_DIVU, 100, 7, 5'd3, 32'd14, 33);
        run_op("rem_m7_2", INST_REM, 32'hFFFF_FFF9, 2, 5'd4, 32'hFFFF_FFFF, 33);
        run_op("div_m7_2", INST_DIV, 32'hFFFF_FFF9, 2, 5'd5, 32'hFFFF_FFFD, 33);
        run_op("divu_by0", INST_DIVU, 1234, 0, 5'd6, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", INST_REMU, 1234, 0, 5'd7, 32'd1234, 1);
        run_op("div_neg_by0", INST_DIV, 32'hFFFF_FFFB, 0, 5'd8, 32'hFFFF_FFFF, 1);
        run_op("rem_neg_by0", INST_REM, 32'hFFFF_FFFB, 0, 5'd8, 32'hFFFF_FFFB, 1);
        run_op("div_ovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 33);
        run_op("rem_ovf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0, 33);
        run_op("divu_max", INST_DIVU, 32'hFFFF_FFFF, 1, 5'd31, 32'hFFFF_FFFF, 33);

        // Non-divide func3 is ignored
        @(posedge clk); #1;
        drive_req(3'b001, 50, 5, 5'd1);
        @(negedge clk);
        check("nondiv_hold", 32'(hold_flag_o), 32'h0);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check("nondiv_busy", 32'(busy_o), 32'h0);

        // Flush at cycle 10, then a new request at cycle 12
        @(posedge clk); #1;
        drive_req(INST_DIVU, 100, 7, 5'd11);
        writes = 0; wcyc = -1; wdata = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            flush_i = (c == 10);
            if (c == 12) drive_req(INST_DIVU, 9, 3, 5'd12);
            @(negedge clk);
            if (c == 11) check("flush_busy_c11", 32'(busy_o), 32'h0);
            if (rd_wen_o) begin
                writes++;
                if (wcyc < 0) begin wcyc = c; wdata = rd_data_o; end
            end
        end
        check("flush_writes", 32'(writes), 32'd1);
        check("flush_new_cycle", 32'(wcyc), 32'd45);
        check("flush_new_data", wdata, 32'd3);

        // Start while busy is ignored
        @(posedge clk); #1;
        drive_req(INST_DIVU, 100, 7, 5'd3);
        writes = 0; wcyc = -1; wdata = '0; waddr = '0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (c == 5) drive_req(INST_DIVU, 50, 5, 5'd9);
            @(negedge clk);
            if (rd_wen_o) begin
                writes++;
                if (wcyc < 0) begin wcyc = c; wdata = rd_data_o; waddr = rd_addr_o; end
            end
        end
        check("busy_start_writes", 32'(writes), 32'd1);
        check("busy_start_cycle", 32'(wcyc), 32'd33);
        check("busy_start_data", wdata, 32'd14);
        check("busy_start_addr", 32'(waddr), 32'd3);

        // Flush in the DONE cycle suppresses the write
        @(posedge clk); #1;
        drive_req(INST_DIVU, 9, 3, 5'd2);
        writes = 0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            flush_i = (c == 33);
            @(negedge clk);
            if (rd_wen_o) writes++;
        end
        flush_i = 1'b0;
        check("flush_done_writes", 32'(writes), 32'd0);

        // Reset at cycle 20 of an operation
        @(posedge clk); #1;
        drive_req(INST_DIVU, 100, 7, 5'd3);
        writes = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (c == 20) begin
                rst_n = 1'b0;
                drive_req(INST_DIVU, 100, 7, 5'd3);
            end
            if (c == 24) begin
                rst_n   = 1'b1;
                start_i = 1'b0;
            end
            @(negedge clk);
            if (c == 20) begin
                check("rst20_ctl", {29'b0, rd_wen_o, busy_o, hold_flag_o}, 32'h0);
                check("rst20_data", rd_data_o, 32'h0);
                check("rst20_addr", 32'(rd_addr_o), 32'h0);
            end
            if (rd_wen_o) writes++;
        end
        check("rst20_writes", 32'(writes), 32'd0);
        run_op("after_rst", INST_DIVU, 100, 7, 5'd3, 32'd14, 33);

        // Randomized traffic checked by the cycle model
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            start_i    = ($urandom_range(0, 2) == 0);
            func3_i    = {($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3))};
            dividend_i = pick_val();
            divisor_i  = pick_val();
            rd_addr_i  = 5'($urandom_range(0, 31));
            flush_i    = ($urandom_range(0, 79) == 0);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("final_idle", 32'(busy_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock, rising-edge active.
REQ-002 The module SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have the port start_i, input, 1 bit: the execute stage requests an RV32M divide (opcode INST_TYPE_R_M, func7 = 0000001, func3[2] = 1).
REQ-004 The module SHALL have the port func3_i, input, 3 bits: operation select, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 The module SHALL have the port dividend_i, input, 32 bits: rs1 value (op1).
REQ-006 The module SHALL have the port divisor_i, input, 32 bits: rs2 value (op2).
REQ-007 The module SHALL have the port rd_addr_i, input, 5 bits: destination register of the request.
REQ-008 The module SHALL have the port flush_i, input, 1 bit: jump or flush from control; aborts the operation in flight.
REQ-009 The module SHALL have the port hold_flag_o, output, 1 bit: stall request to control.
REQ-010 The module SHALL have the port busy_o, output, 1 bit: high when the state is not IDLE.
REQ-011 The module SHALL have the port rd_wen_o, output, 1 bit: one-cycle result-valid and register write enable.
REQ-012 The module SHALL have the port rd_addr_o, output, 5 bits: destination register of the result.
REQ-013 The module SHALL have the port rd_data_o, output, 32 bits: quotient or remainder.

Function
REQ-014 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-015 In IDLE, when start_i=1, flush_i=0 and func3_i[2]=1, the module SHALL latch the operands, func3 and rd_addr; this cycle is cycle 0.
REQ-016 In IDLE, a start_i with func3_i[2]=0 SHALL be ignored.
REQ-017 For signed ops, operands SHALL be converted to magnitudes; the quotient sign SHALL be dividend_sign XOR divisor_sign; the remainder sign SHALL equal dividend_sign.
REQ-018 When divisor=0, IDLE SHALL go to DONE directly with quotient 0xFFFFFFFF and remainder equal to the dividend, unmodified, so rd_wen_o is high in cycle 1.
REQ-019 When divisor!=0, IDLE SHALL go to CALC and perform a 32-iteration restoring division, one quotient bit per clock, MSB first, with a 33-bit partial remainder.
REQ-020 After the 32nd iteration, CALC SHALL go to DONE, so rd_wen_o is high in cycle 33.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV) SHALL yield quotient 0x80000000 and remainder 0 via the normal path.
REQ-022 In DONE, rd_wen_o SHALL be 1 for exactly one cycle, rd_data_o SHALL hold the sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU), and rd_addr_o SHALL hold the latched address; the next state SHALL be IDLE.
REQ-023 In every cycle other than DONE, rd_wen_o, rd_data_o and rd_addr_o SHALL be 0.
REQ-024 hold_flag_o SHALL be combinationally 1 in the accepting IDLE cycle and throughout CALC, and SHALL be 0 in DONE and otherwise.
REQ-025 flush_i=1 in CALC or DONE SHALL force IDLE on the next edge, suppress rd_wen_o in that cycle, and produce no later write.
REQ-026 flush_i=1 in the same cycle as start_i SHALL prevent the request from being accepted.
REQ-027 start_i while busy_o=1 SHALL be ignored, with no queuing.
REQ-028 The iteration counter SHALL be 5 bits, counting 0 to 31, with no wrap beyond one operation.

Reset
REQ-029 While rst_n=0, the state SHALL be IDLE, the counter, operand, quotient and remainder registers SHALL be 0, and all outputs SHALL be 0, regardless of any operation in flight.
REQ-030 The first request after rst_n deasserts SHALL complete with the normal latency, with no extra cycles.

Structure
REQ-031 The divide func3 codes (INST_DIV, INST_DIVU, INST_REM, INST_REMU), the func7 constant 0000001 and the FSM state encodings SHALL be placed in the shared defines file.
REQ-032 A single combinational sub-module div_step SHALL perform one iteration: 33-bit trial subtract producing the next remainder and the quotient bit.
REQ-033 The execute stage SHALL forward start_i and connect hold_flag_o into the control stall OR; the write-back mux SHALL select div_seq outputs when rd_wen_o=1.

Verification
REQ-034 DIVU 100/7 started at cycle 0 -> rd_wen_o=1 at cycle 33 with rd_data_o=14; hold_flag_o high in cycles 0-32.
REQ-035 REM 0xFFFFFFF9 (-7) / 2 -> rd_data_o=0xFFFFFFFF (-1) at cycle 33; DIV of the same operands -> 0xFFFFFFFD (-3).
REQ-036 DIVU 1234/0 -> 0xFFFFFFFF at cycle 1; REMU 1234/0 -> 1234 at cycle 1; hold_flag_o high in cycle 0 only.
REQ-037 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-038 flush_i pulsed at cycle 10 of DIVU 100/7 -> no rd_wen_o ever, busy_o=0 from cycle 11; a new DIVU 9/3 issued at cycle 12 -> 3 at cycle 45.
REQ-039 start_i reasserted at cycle 5 with different operands -> ignored, original result only; rst_n low at cycle 20 -> all outputs 0 immediately and no write afterwards.
